prog_memory: RTL and testbench
==============================

# prog_memory

Unified instruction/data memory for the 8-bit-address, 15-bit-word HMMM processor, sitting on the processor's `mem_write` / `adr` / `mem_data` bus as its responder. It contains a byte-serial program loader. From reset, the loader holds the processor in reset, assembles incoming bytes into 15-bit words from address 0 upward, then releases the processor. In RUN, the block serves combinational reads and clocked 8-bit writes.

## Interface
- `ADDR_W`, 8, address width; depth is 2^ADDR_W words.
- `WORD_W`, 15, memory word width.
- `DATA_W`, 8, processor write-data width; the low bits of `mem_data`.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `load_valid` in 1: a byte is present on `load_byte`.
- `load_byte` in 8: loader byte. Words arrive low byte first; the high byte supplies word bits [14:8] from `load_byte[6:0]`, and bit 7 is ignored.
- `load_last` in 1: sampled with a high-byte transfer only; marks the final word.
- `load_ready` out 1: the loader accepts a byte this cycle.
- `cpu_reset` out 1: drives the processor's reset; high until the load completes.
- `words_loaded` out ADDR_W+1: count of words written by the loader (0..256).
- `mem_write` in 1: processor write strobe.
- `adr` in ADDR_W: processor address.
- `mem_data` inout WORD_W: read data driven by this block; write data on [DATA_W-1:0] driven by the processor.

## Operation
- States:
  - LOAD_LO: wait for the low byte.
  - LOAD_HI: wait for the high byte.
  - RUN: serve the processor.
- Transfer rule: a transfer occurs on a rising `clk` when `load_valid & load_ready`.
- `load_ready` = 1 in LOAD_LO and LOAD_HI; 0 in RUN.
- LOAD_LO transfer: latch `load_byte` into the low-byte holding register, then go to LOAD_HI.
- LOAD_HI transfer:
  - write word {`load_byte[6:0]`, low} to address `load_ptr`;
  - increment `load_ptr` and `words_loaded`.
  - If `load_last`, or `load_ptr` was 255, go to RUN; otherwise go to LOAD_LO.
- Loading exactly 256 words ends the load even without `load_last`. `load_ptr` never wraps.
- `cpu_reset` = 1 in LOAD_LO and LOAD_HI, 0 in RUN. It is a direct flop output and is never derived from combinational decode.
- `mem_write` and `adr` are ignored outside RUN. The processor may strobe `mem_write` spuriously while it is held in reset.
- RUN read: when `mem_write` = 0, drive `mem_data` = mem[`adr`] combinationally (asynchronous read).
- RUN write: when `mem_write` = 1, `mem_data` goes high-Z. At the rising edge, mem[`adr`] <= {7'b0, `mem_data[7:0]`}.
- Outside RUN, `mem_data` is driven only when `mem_write` = 0, with mem[`adr`]. The block never drives the bus while `mem_write` = 1, in any state.
- Memory contents are not reset. Locations not written by the loader are undefined.

## Timing
- Reset (async, any state, including mid-load or mid-run):
  - state = LOAD_LO, `load_ptr` = 0, `words_loaded` = 0;
  - holding register = 0, `cpu_reset` = 1, `load_ready` = 0 while `reset` is high.
- Array contents are retained across reset. A partial (low-only) word pending at reset is discarded.
- Load handshake throughput: one byte per cycle.
- Write latency: the word is visible on a read the cycle after its high-byte transfer edge.
- Release: `cpu_reset` falls at the same edge as the final high-byte transfer. The processor's first fetch from address 0 occurs in the next cycle.
- RUN write is visible on a combinational read the cycle after the write edge.
- `load_valid` in RUN has no effect; no transfer occurs.
- `load_last` on a low-byte transfer is ignored.

## Structure
- Package `hmmm_pkg`:
  - `ADDR_W`, `WORD_W`, `DATA_W` constants;
  - `typedef enum logic [1:0] {LOAD_LO, LOAD_HI, RUN} load_state_t`.
- Sub-module `prog_ram`: 2^ADDR_W × WORD_W array with asynchronous read and one synchronous write port (we, wa, wd).
  - Top level muxes the write port between the loader (LOAD_HI transfer) and the processor (RUN & `mem_write`). The two are exclusive by state.
- Top level holds the FSM, `load_ptr`, the holding register, the counter and the tristate.

## Test plan
- Load 3 words: bytes 0x41,0x00 / 0x12,0x34 / 0xFF,0xFF with `load_last` on the last → mem[0..2] = 0x0041, 0x3412, 0x7FFF. `words_loaded` = 3; `cpu_reset` falls at the 6th transfer edge.
- `load_valid` toggled every other cycle with `load_last` asserted on a low byte → `load_last` ignored; only high-byte `load_last` ends the load; word values correct.
- 256-word load without `load_last` → RUN entered after word 255; `words_loaded` = 256; `load_ready` = 0 afterward; further bytes dropped.
- RUN with `adr` = 0x02, `mem_write` = 1, processor drives 0xA5 on [7:0] → mem[2] = 0x00A5. The next cycle's read with `mem_write` = 0 returns 0x00A5, and the block drives no contention while writing.
- Assert `reset` after a low byte in LOAD_HI, then load 1 word (0x07,0x01, last) → mem[0] = 0x0107; the stale low byte is not used.
- `mem_write` pulsed during load with `adr` = 0 → mem[0] unchanged by the processor path, and `mem_data` is high-Z during the pulse.

Source files
------------

// File: rtl/hmmm_pkg.sv
// Shared constants and loader state type for the HMMM program memory.
package hmmm_pkg;

  localparam int ADDR_W = 8;
  localparam int WORD_W = 15;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    LOAD_LO,
    LOAD_HI,
    RUN
  } load_state_t;

endpackage

// File: rtl/prog_ram.sv
// Word-wide RAM with one asynchronous read port and one synchronous write port.
module prog_ram
  import hmmm_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WORD_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra,
  output logic [WORD_W-1:0] rd
);

  // Contents are deliberately not reset so a loaded program survives a CPU reset.
  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd = mem[ra];

endmodule

// File: rtl/prog_memory.sv
// Unified HMMM instruction/data memory with a byte-serial program loader
// that holds the processor in reset until the program image is in place.
module prog_memory
  import hmmm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_last,
  output logic              load_ready,
  output logic              cpu_reset,
  output logic [ADDR_W:0]   words_loaded,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] adr,
  inout  wire  [WORD_W-1:0] mem_data
);

  load_state_t state, state_next;

  logic [ADDR_W-1:0] load_ptr;
  logic [7:0]        low_hold;
  logic              transfer;
  logic              last_word;
  logic              loader_we;
  logic              cpu_we;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_wa;
  logic [WORD_W-1:0] ram_wd;
  logic [WORD_W-1:0] ram_rd;

  assign transfer  = load_valid & load_ready;
  assign last_word = load_last | (load_ptr == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD_LO;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_LO: if (transfer) state_next = LOAD_HI;
      LOAD_HI: if (transfer) state_next = last_word ? RUN : LOAD_LO;
      RUN:     state_next = RUN;
      default: state_next = LOAD_LO;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    loader_we  = 1'b0;
    cpu_we     = 1'b0;
    case (state)
      LOAD_LO: load_ready = ~reset;
      LOAD_HI: begin
        load_ready = ~reset;
        loader_we  = load_valid & ~reset;
      end
      RUN:     cpu_we = mem_write;
      default: ;
    endcase
  end

  // cpu_reset is registered from the next state so it drops on the final transfer edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_ptr     <= '0;
      words_loaded <= '0;
      low_hold     <= '0;
      cpu_reset    <= 1'b1;
    end else begin
      cpu_reset <= (state_next != RUN);
      if (transfer && state == LOAD_LO) begin
        low_hold <= load_byte;
      end
      if (loader_we) begin
        words_loaded <= words_loaded + 1'b1;
        if (load_ptr != '1) begin
          load_ptr <= load_ptr + 1'b1;
        end
      end
    end
  end

  // Loader and processor writes are exclusive by state, so a simple mux suffices.
  assign ram_we = loader_we | cpu_we;
  assign ram_wa = loader_we ? load_ptr : adr;
  assign ram_wd = loader_we ? {load_byte[6:0], low_hold}
                            : {{(WORD_W-DATA_W){1'b0}}, mem_data[DATA_W-1:0]};

  prog_ram u_ram (
    .clk (clk),
    .we  (ram_we),
    .wa  (ram_wa),
    .wd  (ram_wd),
    .ra  (adr),
    .rd  (ram_rd)
  );

  assign mem_data = mem_write ? {WORD_W{1'bz}} : ram_rd;

endmodule

// File: tb/tb_prog_memory.sv
// Directed bench for prog_memory: a byte-level loader/bus model is compared
// against the DUT every cycle, plus hand-computed literal expectations.
module tb_prog_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_last;
  logic        load_ready;
  logic        cpu_reset;
  logic [8:0]  words_loaded;
  logic        mem_write;
  logic [7:0]  adr;
  wire  [14:0] mem_data;
  logic        drive_en;
  logic [14:0] drive_val;

  int errors = 0;
  int checks = 0;

  logic [14:0] exp_mem [256];
  bit          exp_valid [256];
  int          exp_count = 0;
  bit          exp_done = 1'b0;
  bit          exp_have_low = 1'b0;
  logic [7:0]  exp_low = 8'h00;

  assign mem_data = drive_en ? drive_val : 15'bz;

  always #5 clk = ~clk;

  prog_memory dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_byte    (load_byte),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .cpu_reset    (cpu_reset),
    .words_loaded (words_loaded),
    .mem_write    (mem_write),
    .adr          (adr),
    .mem_data     (mem_data)
  );

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: bytes pair into words until a last-marked high byte or 256 words.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_count    = 0;
      exp_done     = 1'b0;
      exp_have_low = 1'b0;
    end else if (!exp_done) begin
      if (load_valid) begin
        if (!exp_have_low) begin
          exp_low      = load_byte;
          exp_have_low = 1'b1;
        end else begin
          exp_mem[exp_count]   = {load_byte[6:0], exp_low};
          exp_valid[exp_count] = 1'b1;
          exp_count++;
          exp_have_low = 1'b0;
          if (load_last || exp_count == 256) exp_done = 1'b1;
        end
      end
    end else if (mem_write) begin
      exp_mem[adr]   = {7'b0, drive_val[7:0]};
      exp_valid[adr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    checkOutput("load_ready", 16'(load_ready), 16'(!reset && !exp_done));
    checkOutput("cpu_reset", 16'(cpu_reset), 16'(reset || !exp_done));
    checkOutput("words_loaded", 16'(words_loaded), 16'(exp_count));
    if (!mem_write && !drive_en && exp_valid[adr])
      checkOutput("mem_read", 16'(mem_data), 16'(exp_mem[adr]));
  end

  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic l);
    load_valid = v;
    load_byte  = b;
    load_last  = l;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    load_valid = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [7:0] a, input logic [15:0] expected);
    adr = a;
    @(negedge clk);
    checkOutput(name, 16'(mem_data), expected);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; load_byte = 8'h00; load_last = 1'b0;
    mem_write = 1'b0; adr = 8'h00; drive_en = 1'b0; drive_val = 15'h0;
    @(negedge clk);
    checkOutput("reset_load_ready", 16'(load_ready), 16'h0);
    checkOutput("reset_cpu_reset", 16'(cpu_reset), 16'h1);
    checkOutput("reset_words", 16'(words_loaded), 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Three-word load, back to back
    applyStimulus(1'b1, 8'h41, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h12, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    checkOutput("cpu_reset_before_6th", 16'(cpu_reset), 16'h1);
    applyStimulus(1'b1, 8'hFF, 1'b1);
    checkOutput("cpu_reset_after_6th", 16'(cpu_reset), 16'h0);
    checkOutput("words_3", 16'(words_loaded), 16'd3);
    applyStimulus(1'b0, 8'h00, 1'b0);
    readCheck("mem0_0041", 8'd0, 16'h0041);
    readCheck("mem1_3412", 8'd1, 16'h3412);
    readCheck("mem2_7fff", 8'd2, 16'h7FFF);

    // Gapped valid with load_last on low bytes
    adr = 8'd0;
    doReset();
    applyStimulus(1'b1, 8'h10, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h02, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("lo_last_ignored", 16'(cpu_reset), 16'h1);
    applyStimulus(1'b1, 8'h81, 1'b1);
    checkOutput("hi_last_ends", 16'(cpu_reset), 16'h0);
    checkOutput("words_2", 16'(words_loaded), 16'd2);
    applyStimulus(1'b0, 8'h00, 1'b0);
    readCheck("gap_mem0", 8'd0, 16'h0210);
    readCheck("gap_mem1", 8'd1, 16'h0133);

    // Full 256-word load without load_last
    adr = 8'd0;
    doReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 8'(i), 1'b0);
      applyStimulus(1'b1, 8'(i) ^ 8'h5A, 1'b0);
    end
    checkOutput("words_256", 16'(words_loaded), 16'd256);
    checkOutput("ready_after_full", 16'(load_ready), 16'h0);
    checkOutput("cpu_run_after_full", 16'(cpu_reset), 16'h0);
    applyStimulus(1'b1, 8'h55, 1'b1);
    applyStimulus(1'b1, 8'h66, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("words_held_256", 16'(words_loaded), 16'd256);
    readCheck("full_mem255", 8'd255, 16'h25FF);
    readCheck("full_mem0", 8'd0, 16'h5A00);

    // Processor write in RUN
    adr = 8'd2; mem_write = 1'b1; drive_en = 1'b1; drive_val = 15'h00A5;
    @(negedge clk);
    checkOutput("bus_during_write", 16'(mem_data), 16'h00A5);
    @(posedge clk);
    #1;
    mem_write = 1'b0; drive_en = 1'b0;
    readCheck("run_write_mem2", 8'd2, 16'h00A5);

    // Reset while a low byte is pending
    adr = 8'd0;
    doReset();
    applyStimulus(1'b1, 8'h99, 1'b0);
    load_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midload_reset_ready", 16'(load_ready), 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1'b1, 8'h07, 1'b0);
    applyStimulus(1'b1, 8'h01, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    readCheck("stale_low_dropped", 8'd0, 16'h0107);

    // Spurious processor write while held in reset
    doReset();
    applyStimulus(1'b1, 8'h22, 1'b0);
    load_valid = 1'b0;
    adr = 8'd0; mem_write = 1'b1; drive_en = 1'b1; drive_val = 15'h0000;
    @(negedge clk);
    checkOutput("bus_during_load_pulse", 16'(mem_data), 16'h0000);
    @(posedge clk);
    #1;
    mem_write = 1'b0; drive_en = 1'b0;
    readCheck("mem0_after_pulse", 8'd0, 16'h0107);
    applyStimulus(1'b1, 8'h03, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    readCheck("load_after_pulse", 8'd0, 16'h0322);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
